// File: rtl/regs_wr_arbiter.sv
// regs_wr_arbiter
//
// Two-requester round-robin arbiter for a single register-file write port.
// It also has an optional clear sequencer that writes zero to every register.
// All outputs are registered. A grant sampled at edge N drives the write port
// for the cycle after N, and the register file commits it at edge N+1.
//
// Build option:
//   REGS_WR_ARB_CLEAR_EN  defined   -> the clear FSM (IDLE/CLEAR plus counter) is built.
//                         undefined -> clr_start is ignored and clr_busy is tied to 0.
//
// Parameters:
//   DW          data width of the write port
//   AW          address width of the write port (2^AW registers)
//
// Ports:
//   clk         rising-edge clock
//   cr          asynchronous active-low reset
//   req0/req1   write request from requester 0/1; held until its grant is seen
//   addr0/addr1 target register for requester 0/1
//   data0/data1 write data for requester 0/1
//   gnt0/gnt1   one-cycle grant pulse, coincident with the write it causes
//   clr_start   single-cycle pulse requesting a clear of all registers
//   clr_busy    high while the clear sequence is writing
//   WE          register-file write enable
//   Addr_W      register-file write address
//   Di          register-file write data
module regs_wr_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          cr,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    output logic          gnt0,
    output logic          gnt1,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          WE,
    output logic [AW-1:0] Addr_W,
    output logic [DW-1:0] Di
);

    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] di_q, di_d;
    logic          busy_q, busy_d;
    // Set when requester 1 should win the next contention.
    logic          prio1_q, prio1_d;

    // Decisions that the clear sequencer hands to the output logic.
    logic          arb_en;      // the next cycle is free for a grant
    logic          clear_out;   // the next cycle is a clear write
    logic [AW-1:0] clear_addr;  // address of that clear write

    logic elig0, elig1, pick0, pick1;

`ifdef REGS_WR_ARB_CLEAR_EN
    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // State register
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. While in StClear, cnt_q is the address on Addr_W in
    // the current cycle. clr_start is only looked at in StIdle, so a clear
    // that is already running cannot be restarted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Arbitration is allowed only when the next cycle is not a clear write.
    // A clr_start sampled together with a request therefore wins, and the
    // request stays pending until the sequence finishes.
    assign arb_en     = (state_d == StIdle);
    assign clear_out  = (state_d == StClear);
    assign clear_addr = cnt_d;
`else
    logic unused_clr_start;

    assign unused_clr_start = clr_start;
    assign arb_en           = 1'b1;
    assign clear_out        = 1'b0;
    assign clear_addr       = '0;
`endif

    // Output / arbitration logic. It computes the values that the output
    // registers will hold in the next cycle.
    always_comb begin
        // A requester whose grant is showing now has already been served.
        elig0 = req0 & ~gnt0_q;
        elig1 = req1 & ~gnt1_q;
        pick0 = arb_en & elig0 & (~elig1 | ~prio1_q);
        pick1 = arb_en & elig1 & (~elig0 | prio1_q);

        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        di_d    = '0;
        busy_d  = 1'b0;
        prio1_d = prio1_q;

        if (clear_out) begin
            we_d   = 1'b1;
            addr_d = clear_addr;
            busy_d = 1'b1;
        end else if (pick0) begin
            gnt0_d  = 1'b1;
            we_d    = 1'b1;
            addr_d  = addr0;
            di_d    = data0;
            prio1_d = 1'b1;
        end else if (pick1) begin
            gnt1_d  = 1'b1;
            we_d    = 1'b1;
            addr_d  = addr1;
            di_d    = data1;
            prio1_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            di_q    <= '0;
            busy_q  <= 1'b0;
            prio1_q <= 1'b0;
        end else begin
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            busy_q  <= busy_d;
            prio1_q <= prio1_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign WE       = we_q;
    assign Addr_W   = addr_q;
    assign Di       = di_q;
    assign clr_busy = busy_q;

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Testbench for regs_wr_arbiter. It uses a behavioural model that is checked
// every cycle, together with directed scenarios that carry literal
// expectations. Clear-sequence scenarios are compiled only when
// REGS_WR_ARB_CLEAR_EN is defined.
module tb_regs_wr_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 3;
    localparam int NREG = 8;
`ifdef REGS_WR_ARB_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          cr = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, clr_start = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          gnt0, gnt1, clr_busy, WE;
    logic [AW-1:0] Addr_W;
    logic [DW-1:0] Di;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    regs_wr_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .cr        (cr),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .WE        (WE),
        .Addr_W    (Addr_W),
        .Di        (Di)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. clr_addr is the address of the current clear write,
    // or -1 when no clear is running. rr_next says who wins a tie.
    bit            e_g0 = 0, e_g1 = 0, e_we = 0, e_busy = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_di = '0;
    int            clr_addr = -1;
    int            rr_next = 0;
    int            win;
    bit            c0, c1;

    always @(posedge clk or negedge cr) begin
        if (!cr) begin
            {e_g0, e_g1, e_we, e_busy} = '0;
            e_addr   = '0;
            e_di     = '0;
            clr_addr = -1;
            rr_next  = 0;
        end else begin
            c0  = req0 && !e_g0;
            c1  = req1 && !e_g1;
            win = -1;
            if (clr_addr >= 0) clr_addr = (clr_addr == NREG - 1) ? -1 : clr_addr + 1;
            else if (CLEAR_EN && clr_start) clr_addr = 0;
            if (clr_addr < 0) begin
                if (c0 && c1) win = rr_next;
                else if (c0) win = 0;
                else if (c1) win = 1;
                if (win >= 0) rr_next = 1 - win;
            end
            e_g0   = (win == 0);
            e_g1   = (win == 1);
            e_busy = (clr_addr >= 0);
            e_we   = e_busy || (win >= 0);
            e_addr = e_busy ? AW'(clr_addr) : (win == 0) ? addr0 : (win == 1) ? addr1 : '0;
            e_di   = (win == 0) ? data0 : (win == 1) ? data1 : '0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_gnt0", gnt0, e_g0);
            chk("m_gnt1", gnt1, e_g1);
            chk("m_we", WE, e_we);
            chk("m_addr", Addr_W, e_addr);
            chk("m_di", Di, e_di);
            chk("m_busy", clr_busy, e_busy);
            chk("gnt_exclusive", gnt0 & gnt1, 0);
        end
    end

    // Register file fed by the DUT write port.
    logic [DW-1:0] rf [NREG];
    always @(posedge clk) if (cr && WE) rf[Addr_W] <= Di;

    // Requester agents: on seeing a grant, present the next transfer or stop.
    int left0 = 0, left1 = 0;
    int grants[$];

    task automatic step();
        @(negedge clk);
        if (gnt0) begin
            grants.push_back(0);
            if (left0 > 0) begin
                left0--;
                if (left0 == 0) req0 = 1'b0;
                else begin addr0 = addr0 + 1'b1; data0 = $urandom; end
            end
        end
        if (gnt1) begin
            grants.push_back(1);
            if (left1 > 0) begin
                left1--;
                if (left1 == 0) req1 = 1'b0;
                else begin addr1 = addr1 + 1'b1; data1 = $urandom; end
            end
        end
    endtask

    task automatic start0(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d);
        left0 = n; addr0 = a; data0 = d; req0 = 1'b1;
    endtask

    task automatic start1(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d);
        left1 = n; addr1 = a; data1 = d; req1 = 1'b1;
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0; left0 = 0; left1 = 0; clr_start = 1'b0;
        cr = 1'b0;
        repeat (2) step();
        cr = 1'b1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_gnt0"}, gnt0, 0);
        chk({name, "_gnt1"}, gnt1, 0);
        chk({name, "_we"}, WE, 0);
        chk({name, "_addr"}, Addr_W, 0);
        chk({name, "_di"}, Di, 0);
        chk({name, "_busy"}, clr_busy, 0);
    endtask

    logic [5:0] pat;
    int         n_clr;
    bit         found;

    initial begin
        #2 chk_en = 1'b1;
        step();
        chk_all_zero("reset");
        cr = 1'b1;

        // Single write right after reset release.
        start0(1, 3'd3, 32'hDEAD_BEEF);
        step();
        chk("w1_gnt0", gnt0, 1);
        chk("w1_gnt1", gnt1, 0);
        chk("w1_we", WE, 1);
        chk("w1_addr", Addr_W, 3);
        chk("w1_di", Di, 32'hDEAD_BEEF);
        step();
        chk("w1_we_off", WE, 0);

        // Lone requester with continuous transfers: granted every other cycle.
        start0(3, 3'd1, 32'h0000_0011);
        for (int i = 5; i >= 0; i--) begin
            step();
            pat[i] = gnt0;
        end
        chk("lone_pattern", pat, 6'b101010);

        // Contention from reset: 0 first, then strict alternation, no gaps.
        do_reset();
        grants.delete();
        start0(4, 3'd0, 32'h0000_00A0);
        start1(4, 3'd4, 32'h0000_00B0);
        repeat (8) step();
        chk("rr_count", grants.size(), 8);
        for (int i = 0; i < 8 && i < grants.size(); i++) chk("rr_order", grants[i], i % 2);
        step();
        chk("rr_count_final", grants.size(), 8);

`ifdef REGS_WR_ARB_CLEAR_EN
        // Full clear sequence.
        step();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (i > 0) step();
            chk("clr_we", WE, 1);
            chk("clr_addr", Addr_W, i);
            chk("clr_di", Di, 0);
            chk("clr_busy", clr_busy, 1);
        end
        step();
        chk("clr_done_busy", clr_busy, 0);
        chk("clr_done_we", WE, 0);
        for (int i = 0; i < NREG; i++) chk("clr_rf_zero", rf[i], 0);

        // Clear and request sampled together: clear first, then the grant.
        step();
        clr_start = 1'b1;
        start1(1, 3'd5, 32'h1234_5678);
        step();
        clr_start = 1'b0;
        found = 1'b0;
        n_clr = 0;
        for (int k = 0; k < 12; k++) begin
            if (gnt1) begin found = 1'b1; break; end
            if (clr_busy && WE) n_clr++;
            step();
        end
        chk("cg_found", found, 1);
        chk("cg_nclr", n_clr, 8);
        chk("cg_addr", Addr_W, 5);
        chk("cg_di", Di, 32'h1234_5678);
        chk("cg_busy", clr_busy, 0);

        // Reset in the middle of a clear aborts it for good.
        step();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (clr_busy && Addr_W == 3'd4) begin found = 1'b1; break; end
            step();
        end
        chk("ra_hit4", found, 1);
        #2 cr = 1'b0;
        #1 chk_all_zero("ra_async");
        step();
        cr = 1'b1;
        repeat (6) begin
            step();
            chk("ra_no_we", WE, 0);
            chk("ra_no_busy", clr_busy, 0);
        end
`else
        // Clear disabled: clr_start has no effect and arbitration is unchanged.
        step();
        clr_start = 1'b1;
        start0(1, 3'd6, 32'h0000_0055);
        step();
        clr_start = 1'b0;
        chk("nc_gnt0", gnt0, 1);
        chk("nc_addr", Addr_W, 6);
        chk("nc_busy", clr_busy, 0);
        step();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (8) begin
            step();
            chk("nc_no_busy", clr_busy, 0);
            chk("nc_no_we", WE, 0);
        end

        // Reset during a grant clears the outputs without waiting for a clock.
        start1(1, 3'd2, 32'h0000_0077);
        step();
        chk("ra_gnt1", gnt1, 1);
        #2 cr = 1'b0;
        #1 chk_all_zero("ra_async");
        step();
        cr = 1'b1;
        repeat (3) begin
            step();
            chk("ra_no_we", WE, 0);
        end
`endif

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/regs_wr_arbiter.md
REGS_WR_ARBITER -- requirements
Module: regs_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, the data width of the register-file write port.
REQ-002 The block SHALL have parameter AW, default 3, the address width of the register-file write port (2^AW registers).
REQ-003 The block SHALL have port clk, input, 1, the single clock; every state element is rising-edge clocked.
REQ-004 The block SHALL have port cr, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports req0/req1, input, 1 each, write request from requester 0/1.
REQ-006 The block SHALL have ports addr0/addr1, input, AW each, target register for requester 0/1.
REQ-007 The block SHALL have ports data0/data1, input, DW each, write data for requester 0/1.
REQ-008 The block SHALL have ports gnt0/gnt1, output, 1 each, one-cycle grant pulse to requester 0/1.
REQ-009 The block SHALL have port clr_start, input, 1, single-cycle pulse that requests a clear of all registers.
REQ-010 The block SHALL have port clr_busy, output, 1, high while the clear sequence runs.
REQ-011 The block SHALL have ports WE (1), Addr_W (AW), Di (DW), outputs, connected to the register-file write port.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 At each rising edge the arbiter SHALL sample req0/req1 and, if it selects requester i, drive gnt_i=1, WE=1, Addr_W=addr_i, Di=data_i for exactly the following cycle; the register file commits on the next edge (request-to-write latency 2 edges).
REQ-014 A requester SHALL hold req, addr and data stable until it samples its gnt high, then deassert req or present a new transfer.
REQ-015 A requester whose gnt is high at an edge SHALL be ineligible at that edge (no double grant for one transfer).
REQ-016 With only one eligible request it SHALL be granted; with both eligible, the requester not granted most recently SHALL win (round-robin); after reset, requester 0 wins the first contention.
REQ-017 gnt0 and gnt1 SHALL never be high together; with no grant or clear, WE=0, Addr_W=0, Di=0.
REQ-018 Back-to-back alternating grants (gnt0 cycle k, gnt1 cycle k+1) SHALL be supported with no idle cycle.
REQ-019 The clear FSM SHALL have states IDLE and CLEAR plus an AW-bit counter; clr_start sampled high in IDLE moves to CLEAR with counter 0.
REQ-020 In CLEAR, each cycle SHALL drive WE=1, Addr_W=counter, Di=0, clr_busy=1, counter incrementing; after address 2^AW-1 return to IDLE, clr_busy=0 the following cycle.
REQ-021 When clr_start and a request are sampled at the same edge, the clear SHALL win; the request stays pending and is arbitrated after the clear completes.
REQ-022 No grant SHALL be issued while clr_busy is high; clr_start during CLEAR SHALL be ignored (no restart).
REQ-023 A grant already driven when clr_start is sampled SHALL complete; CLEAR begins the next cycle.

Reset
REQ-024 cr low SHALL immediately force gnt0=gnt1=0, WE=0, Addr_W=0, Di=0, clr_busy=0, FSM=IDLE, counter=0, round-robin pointer to "requester 0 next", regardless of clk.
REQ-025 Reset asserted mid-clear SHALL abort the clear; no resumption after release.
REQ-026 The first grant after cr rises SHALL be based on requests sampled at the first rising edge with cr high.

Configuration
REQ-027 Macro REGS_WR_ARB_CLEAR_EN defined: clear FSM built per REQ-019..REQ-023.
REQ-028 Macro REGS_WR_ARB_CLEAR_EN undefined: clear FSM omitted, clr_start port present but ignored, clr_busy tied 0, arbitration unchanged.

Verification
REQ-029 Reset then req0=1, addr0=3, data0=0xDEADBEEF -> next cycle gnt0=1, WE=1, Addr_W=3, Di=0xDEADBEEF; one cycle later WE=0.
REQ-030 req0 and req1 held high with new data after each grant -> gnt sequence 0,1,0,1..., one grant per cycle, never both high.
REQ-031 clr_start pulse with REGS_WR_ARB_CLEAR_EN -> 8 cycles WE=1, Addr_W=0..7, Di=0, clr_busy=1; all registers read 0 afterwards.
REQ-032 clr_start and req1 (addr1=5, data1=0x12345678) at same edge -> clear of 8 registers first, then gnt1 with Addr_W=5, Di=0x12345678.
REQ-033 cr pulled low at clear address 4 -> all outputs 0 immediately; after release no WE without new request or clr_start.
REQ-034 Macro undefined, clr_start pulsed -> clr_busy stays 0, WE stays 0.
